// File: rtl/vdp_super_res_vram_port.sv
// VRAM port sequencer for the super-res pixel stage: slices the 32-bit memory port
// into DL/DA/DW/FS slots and serves video fetches, CPU byte accesses and refresh.
module vdp_super_res_vram_port #(
  parameter int MEM_LATENCY      = 2,
  parameter int REFRESH_INTERVAL = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] cx,
  input  logic        super_res_drawing,
  input  logic [16:0] super_res_vram_addr,
  output logic [31:0] vrm_32,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [1:0]  mem_cmd,
  output logic [14:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
);

  localparam logic [1:0] SLOT_DA  = 2'd1;
  localparam logic [1:0] SLOT_DW  = 2'd2;
  localparam logic [1:0] SLOT_FS  = 2'd3;
  localparam logic [1:0] CMD_IDLE = 2'd0;
  localparam logic [1:0] CMD_RD   = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_REF  = 2'd3;
  localparam logic [7:0] REF_LAST = 8'(REFRESH_INTERVAL - 1);

  typedef struct packed {
    logic       vld;
    logic       cpu;
    logic [1:0] bsel;
  } tag_t;

  logic [7:0]  r_ref_cnt;
  logic        r_cpu_pending;
  tag_t        r_iss_tag;
  tag_t        r_tag_p [MEM_LATENCY];
  tag_t        w_head;
  tag_t        w_tag;
  logic        w_cpu_slot;
  logic        w_cpu_go;
  logic        w_wr_ack;
  logic [1:0]  w_cmd;
  logic [14:0] w_addr;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_unused   = ^{cx[10:2], super_res_vram_addr[1:0]};
  assign w_head     = r_tag_p[MEM_LATENCY-1];
  // The CPU owns DW, and DA whenever video is not drawing; cpu_ack blocks a re-issue
  // on the cycle the host is still dropping its request.
  assign w_cpu_slot = (cx[1:0] == SLOT_DW) || ((cx[1:0] == SLOT_DA) && !super_res_drawing);
  assign w_cpu_go   = w_cpu_slot && cpu_req && !r_cpu_pending && !cpu_ack;

  always_comb begin
    w_cmd    = CMD_IDLE;
    w_addr   = mem_addr;
    w_wmask  = 4'b0000;
    w_wdata  = mem_wdata;
    w_tag    = '0;
    w_wr_ack = 1'b0;
    if (cx[1:0] == SLOT_FS) begin
      if (r_ref_cnt == REF_LAST) w_cmd = CMD_REF;
    end else if ((cx[1:0] == SLOT_DA) && super_res_drawing) begin
      w_cmd  = CMD_RD;
      w_addr = super_res_vram_addr[16:2];
      w_tag  = tag_t'{vld: 1'b1, cpu: 1'b0, bsel: 2'b00};
    end else if (w_cpu_go) begin
      w_addr = cpu_addr[16:2];
      if (cpu_wr) begin
        w_cmd    = CMD_WR;
        w_wmask  = 4'b0001 << cpu_addr[1:0];
        w_wdata  = {4{cpu_wdata}};
        w_wr_ack = 1'b1;
      end else begin
        w_cmd = CMD_RD;
        w_tag = tag_t'{vld: 1'b1, cpu: 1'b1, bsel: cpu_addr[1:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vrm_32        <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      mem_cmd       <= CMD_IDLE;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      r_ref_cnt     <= '0;
      r_cpu_pending <= 1'b0;
      r_iss_tag     <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) r_tag_p[i] <= '0;
    end else begin
      mem_cmd   <= w_cmd;
      mem_addr  <= w_addr;
      mem_wdata <= w_wdata;
      mem_wmask <= w_wmask;
      cpu_ack   <= w_wr_ack;
      // Tag rides with mem_cmd, then shifts so the head lines up with mem_rvalid.
      r_iss_tag  <= w_tag;
      r_tag_p[0] <= r_iss_tag;
      for (int i = 1; i < MEM_LATENCY; i++) r_tag_p[i] <= r_tag_p[i-1];
      if (cx[1:0] == SLOT_FS) begin
        r_ref_cnt <= (r_ref_cnt == REF_LAST) ? 8'd0 : r_ref_cnt + 8'd1;
      end
      if (w_tag.vld && w_tag.cpu) r_cpu_pending <= 1'b1;
      if (mem_rvalid && w_head.vld) begin
        if (w_head.cpu) begin
          cpu_rdata     <= mem_rdata[{w_head.bsel, 3'b000} +: 8];
          cpu_ack       <= 1'b1;
          r_cpu_pending <= 1'b0;
        end else begin
          vrm_32 <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp_super_res_vram_port.sv
// Bench for vdp_super_res_vram_port: memory model plus a slot-rule reference model,
// directed scenarios followed by randomized video/CPU traffic.
module tb_vdp_super_res_vram_port;

  localparam int LAT = 2;
  localparam int RI  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] cx = 11'h7FF;
  logic        super_res_drawing = 1'b0;
  logic [16:0] super_res_vram_addr = '0;
  logic [31:0] vrm_32;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [1:0]  mem_cmd;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  vdp_super_res_vram_port #(.MEM_LATENCY(LAT), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .reset_n(reset_n), .cx(cx),
    .super_res_drawing(super_res_drawing), .super_res_vram_addr(super_res_vram_addr),
    .vrm_32(vrm_32), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  // Memory: word array, read data returned LAT cycles after the read command cycle.
  logic [31:0] mem    [32768];
  logic [31:0] shadow [32768];
  logic        pv [4];
  logic [31:0] pd [4];

  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = (mem_cmd == 2'd1);
    pd[0] = mem[mem_addr];
    if (mem_cmd == 2'd2)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
    mem_rvalid = pv[LAT];
    mem_rdata  = pd[LAT];
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          stepn = 0;
  int          ack_step = -1;
  int          fs_count = 0;
  int          acks_seen = 0;
  int          refs_seen = 0;
  int          a0;
  int          r0;
  int          vq_step [$];
  logic [31:0] vq_val [$];
  logic [1:0]  exp_cmd = 2'd0;
  logic [14:0] exp_addr = '0;
  logic [3:0]  exp_wmask = '0;
  logic [31:0] exp_wdata = '0;
  logic [31:0] exp_vrm = '0;
  logic [7:0]  exp_rdata = '0;
  logic [7:0]  pend_rdata = '0;
  logic        ack_is_rd = 1'b0;
  logic        cpu_issued = 1'b0;
  logic        do_rst = 1'b1;
  logic        rst_prev = 1'b1;
  logic        drw = 1'b0;
  logic [16:0] vaddr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, stepn);
    end
  endtask

  task automatic cpu_start(input logic wr, input logic [16:0] a, input logic [7:0] d);
    cpu_wr    = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_req   = 1'b1;
  endtask

  // One clock: check what the previous cycle produced, then drive and predict this cycle.
  task automatic step();
    logic [1:0]  s;
    logic [14:0] w;
    logic [1:0]  bs;
    @(negedge clk);
    stepn++;
    chk("mem_cmd", 32'(mem_cmd), 32'(exp_cmd));
    if (exp_cmd == 2'd1 || exp_cmd == 2'd2) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
    if (exp_cmd == 2'd2) begin
      chk("mem_wmask", 32'(mem_wmask), 32'(exp_wmask));
      chk("mem_wdata", mem_wdata, exp_wdata);
    end
    if (rst_prev) begin
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    end
    if (vq_step.size() > 0 && vq_step[0] == stepn) begin
      exp_vrm = vq_val.pop_front();
      void'(vq_step.pop_front());
    end
    chk("vrm_32", vrm_32, exp_vrm);
    if (stepn == ack_step && ack_is_rd) exp_rdata = pend_rdata;
    chk("cpu_ack", 32'(cpu_ack), 32'(stepn == ack_step));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    if (cpu_ack) acks_seen++;
    if (mem_cmd == 2'd3) refs_seen++;
    if (stepn == ack_step) begin
      cpu_req    = 1'b0;
      cpu_issued = 1'b0;
    end
    cx                  = cx + 11'd1;
    super_res_drawing   = drw;
    super_res_vram_addr = vaddr;
    exp_cmd             = 2'd0;
    rst_prev            = do_rst;
    if (do_rst) begin
      #1 reset_n = 1'b0;
      cpu_req    = 1'b0;
      cpu_issued = 1'b0;
      ack_step   = -1;
      exp_vrm    = '0;
      exp_rdata  = '0;
      fs_count   = 0;
      vq_step.delete();
      vq_val.delete();
    end else begin
      reset_n = 1'b1;
      s  = cx[1:0];
      w  = cpu_addr[16:2];
      bs = cpu_addr[1:0];
      if (s == 2'd3) begin
        fs_count++;
        if (fs_count % RI == 0) exp_cmd = 2'd3;
      end else if (s == 2'd1 && drw) begin
        exp_cmd  = 2'd1;
        exp_addr = vaddr[16:2];
        vq_step.push_back(stepn + 2 + LAT);
        vq_val.push_back(shadow[vaddr[16:2]]);
      end else if ((s == 2'd1 || s == 2'd2) && cpu_req && !cpu_issued) begin
        exp_addr   = w;
        cpu_issued = 1'b1;
        if (cpu_wr) begin
          exp_cmd   = 2'd2;
          exp_wmask = 4'b0001 << bs;
          exp_wdata = {4{cpu_wdata}};
          ack_step  = stepn + 1;
          ack_is_rd = 1'b0;
          shadow[w][8*bs +: 8] = cpu_wdata;
        end else begin
          exp_cmd    = 2'd1;
          ack_step   = stepn + 2 + LAT;
          ack_is_rd  = 1'b1;
          pend_rdata = shadow[w][8*bs +: 8];
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    for (int i = 0; i < 32768; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    mem[0] = 32'hAAAA0001; shadow[0] = mem[0];
    mem[1] = 32'hBBBB0002; shadow[1] = mem[1];
    mem[2] = 32'hCCCC0003; shadow[2] = mem[2];

    // Reset for one full group; cx then sits on a group boundary.
    repeat (4) step();
    do_rst = 1'b0;

    // Video fetches of words 0,1,2 in consecutive groups.
    drw = 1'b1; vaddr = 17'h00000;
    repeat (4) step();
    vaddr = 17'h00004; step(); step(); chk("vid_A", vrm_32, 32'hAAAA0001); step(); step();
    vaddr = 17'h00008; step(); step(); chk("vid_B", vrm_32, 32'hBBBB0002); step(); step();
    drw = 1'b0;        step(); step(); chk("vid_C", vrm_32, 32'hCCCC0003); step(); step();

    // CPU write in DW while drawing.
    drw = 1'b1;
    a0 = acks_seen;
    cpu_start(1'b1, 17'h00006, 8'h5A);
    repeat (8) step();
    chk("wr_ack_count", 32'(acks_seen - a0), 32'd1);
    chk("wr_mem_lane2", 32'(mem[1][23:16]), 32'h5A);

    // CPU read of byte 3 while drawing.
    mem[0] = 32'h11223344; shadow[0] = mem[0];
    cpu_start(1'b0, 17'h00003, 8'h00);
    repeat (12) step();
    chk("rd_byte", 32'(cpu_rdata), 32'h11);

    // Not drawing: CPU read and write go out in the DA slot.
    drw = 1'b0;
    cpu_start(1'b0, 17'h00006, 8'h00);
    repeat (8) step();
    chk("rd_written_byte", 32'(cpu_rdata), 32'h5A);
    cpu_start(1'b1, 17'h1FFFD, 8'hC3);
    repeat (8) step();

    // Refresh cadence over sixteen groups.
    r0 = refs_seen;
    repeat (64) step();
    chk("refresh_count", 32'(refs_seen - r0), 32'd2);

    // Reset with a video read in flight; its late return must be ignored.
    mem[4] = 32'hCAFEF00D; shadow[4] = mem[4];
    drw = 1'b1; vaddr = 17'h00010;
    step(); step();
    do_rst = 1'b1; step();
    do_rst = 1'b0; drw = 1'b0;
    repeat (5) step();
    chk("rst_late_vrm", vrm_32, 32'd0);

    // Randomized traffic.
    for (int g = 0; g < 500; g++) begin
      drw   = ($urandom_range(0, 3) != 0);
      vaddr = 17'($urandom);
      if (!cpu_req && $urandom_range(0, 1) == 1)
        cpu_start(1'($urandom_range(0, 1)), 17'($urandom), 8'($urandom));
      repeat (4) step();
    end
    cpu_req = 1'b0;
    drw = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
